// File: rtl/idex_hazard_ctrl_pkg.sv
// Shared definitions for the ID/EX hazard controller: state encoding,
// control field widths and the load-use hazard test.
package idex_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN_WAIT = 2'd0,
    IDLE     = 2'd1,
    STALL    = 2'd2
  } state_e;

  localparam int WB_W     = 2;
  localparam int M_W      = 2;
  localparam int EX_W     = 4;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;
  localparam int REG_W    = 5;
  // Remaining-bubble counter width; enough for LOAD_STALL up to 7.
  localparam int REM_W    = 3;

  // A load in ID/EX whose destination is read by the instruction in IF/ID.
  // Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic             mem_read,
    input logic [REG_W-1:0] idex_rt,
    input logic [REG_W-1:0] ifid_rs,
    input logic [REG_W-1:0] ifid_rt,
    input logic             ifid_use_rt
  );
    return mem_read && (idex_rt != '0) &&
           ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));
  endfunction

endpackage

// File: rtl/idex_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard statistics; holds at all-ones.
module sat_counter
  import idex_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: step on inc unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/idex_hazard_ctrl.sv
// Decode-stage hazard controller: detects load-use hazards against ID/EX,
// stalls PC and IF/ID while injecting bubbles into ID/EX, flushes IF/ID on
// taken branches and keeps saturating hazard statistics.
module idex_hazard_ctrl
  import idex_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [M_W-1:0]   idex_M_i,
  input  logic [REG_W-1:0] idex_rt_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_use_rt_i,
  input  logic             branch_taken_i,
  input  logic [WB_W-1:0]  ctrl_WB_i,
  input  logic [M_W-1:0]   ctrl_M_i,
  input  logic [EX_W-1:0]  ctrl_EX_i,
  output logic [WB_W-1:0]  WB_o,
  output logic [M_W-1:0]   M_o,
  output logic [EX_W-1:0]  EX_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Extra bubbles beyond the first one issued from IDLE.
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_STALL - 1);

  state_e           state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             haz;
  logic             bubble;
  logic             stall_inc;
  logic             flush_inc;

  // MemWrite in ID/EX does not create a load-use dependency.
  logic unused_memwrite;
  assign unused_memwrite = idex_M_i[MEMWRITE];

  // Load-use hazard against the instruction currently held in IF/ID.
  always_comb begin
    haz = load_use_hazard(idex_M_i[MEMREAD], idex_rt_i, ifid_rs_i,
                          ifid_rt_i, ifid_use_rt_i);
  end

  // Next state, bubble remainder and stage enables; stall beats branch.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    bubble       = 1'b1;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state_q)
      RUN_WAIT: begin
        state_d = IDLE;
      end
      IDLE: begin
        if (haz) begin
          stall_inc = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = STALL;
            rem_d   = REM_INIT;
          end
        end else begin
          bubble       = 1'b0;
          pc_write_o   = 1'b1;
          ifid_write_o = 1'b1;
          if (branch_taken_i) begin
            ifid_flush_o = 1'b1;
            flush_inc    = 1'b1;
          end
        end
      end
      STALL: begin
        stall_inc = 1'b1;
        if (rem_q <= REM_W'(1)) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - REM_W'(1);
        end
      end
      default: begin
        state_d = RUN_WAIT;
        rem_d   = '0;
      end
    endcase
  end

  // Control fields forwarded to ID/EX, zeroed whenever a bubble is issued.
  always_comb begin
    WB_o = bubble ? '0 : ctrl_WB_i;
    M_o  = bubble ? '0 : ctrl_M_i;
    EX_o = bubble ? '0 : ctrl_EX_i;
  end

  // State and bubble remainder registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN_WAIT;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_inc),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_inc),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Self-checking bench for idex_hazard_ctrl: a table of directed vectors on a
// LOAD_STALL=1 instance, plus hand sequences for a LOAD_STALL=3 instance
// and a narrow-counter instance used for saturation.
module tb_idex_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] idex_m;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       use_rt;
  logic       br_taken;
  logic [1:0] ctrl_wb;
  logic [1:0] ctrl_m;
  logic [3:0] ctrl_ex;

  logic [1:0]  wb_a, m_a, wb_b, m_b, wb_c, m_c;
  logic [3:0]  ex_a, ex_b, ex_c;
  logic        pcw_a, ifw_a, fl_a, pcw_b, ifw_b, fl_b, pcw_c, ifw_c, fl_c;
  logic [15:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
  logic [2:0]  scnt_c, fcnt_c;

  int n_checks = 0;
  int n_fails  = 0;

  idex_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .idex_M_i(idex_m), .idex_rt_i(idex_rt),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_use_rt_i(use_rt),
    .branch_taken_i(br_taken), .ctrl_WB_i(ctrl_wb), .ctrl_M_i(ctrl_m),
    .ctrl_EX_i(ctrl_ex), .WB_o(wb_a), .M_o(m_a), .EX_o(ex_a),
    .pc_write_o(pcw_a), .ifid_write_o(ifw_a), .ifid_flush_o(fl_a),
    .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a));

  idex_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .idex_M_i(idex_m), .idex_rt_i(idex_rt),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_use_rt_i(use_rt),
    .branch_taken_i(br_taken), .ctrl_WB_i(ctrl_wb), .ctrl_M_i(ctrl_m),
    .ctrl_EX_i(ctrl_ex), .WB_o(wb_b), .M_o(m_b), .EX_o(ex_b),
    .pc_write_o(pcw_b), .ifid_write_o(ifw_b), .ifid_flush_o(fl_b),
    .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b));

  idex_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(3)) dut_c (
    .clk_i(clk), .rst_i(rst_n), .idex_M_i(idex_m), .idex_rt_i(idex_rt),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_use_rt_i(use_rt),
    .branch_taken_i(br_taken), .ctrl_WB_i(ctrl_wb), .ctrl_M_i(ctrl_m),
    .ctrl_EX_i(ctrl_ex), .WB_o(wb_c), .M_o(m_c), .EX_o(ex_c),
    .pc_write_o(pcw_c), .ifid_write_o(ifw_c), .ifid_flush_o(fl_c),
    .stall_cnt_o(scnt_c), .flush_cnt_o(fcnt_c));

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [1:0]  idex_m;
    logic [4:0]  idex_rt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rt;
    logic        br;
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [3:0]  ex;
    logic        exp_pc;
    logic        exp_ifid;
    logic        exp_flush;
    logic        exp_pass;
    logic [15:0] exp_stall;
    logic [15:0] exp_fcnt;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t make_vec(
    input logic [1:0] im, input logic [4:0] irt, input logic [4:0] rs,
    input logic [4:0] rt, input logic ur, input logic br,
    input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
    input logic epc, input logic eifid, input logic efl, input logic epass,
    input logic [15:0] es, input logic [15:0] ef);
    vec_t v;
    v.idex_m = im;  v.idex_rt = irt; v.rs = rs; v.rt = rt;
    v.use_rt = ur;  v.br = br; v.wb = wb; v.m = m; v.ex = ex;
    v.exp_pc = epc; v.exp_ifid = eifid; v.exp_flush = efl;
    v.exp_pass = epass; v.exp_stall = es; v.exp_fcnt = ef;
    return v;
  endfunction

  task automatic applyStimulus(input logic [1:0] im, input logic [4:0] irt,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic ur, input logic br);
    idex_m   = im;
    idex_rt  = irt;
    ifid_rs  = rs;
    ifid_rt  = rt;
    use_rt   = ur;
    br_taken = br;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every stage-control output of instance A (sel 0) or B (sel 1).
  task automatic checkCtrl(input string tag, input int sel, input logic pc,
                           input logic ifid, input logic fl,
                           input logic [1:0] wb, input logic [1:0] m,
                           input logic [3:0] ex);
    if (sel == 0) begin
      checkOutput({tag, " pc_write"},   16'(pcw_a), 16'(pc));
      checkOutput({tag, " ifid_write"}, 16'(ifw_a), 16'(ifid));
      checkOutput({tag, " ifid_flush"}, 16'(fl_a),  16'(fl));
      checkOutput({tag, " WB"},         16'(wb_a),  16'(wb));
      checkOutput({tag, " M"},          16'(m_a),   16'(m));
      checkOutput({tag, " EX"},         16'(ex_a),  16'(ex));
    end else begin
      checkOutput({tag, " pc_write"},   16'(pcw_b), 16'(pc));
      checkOutput({tag, " ifid_write"}, 16'(ifw_b), 16'(ifid));
      checkOutput({tag, " ifid_flush"}, 16'(fl_b),  16'(fl));
      checkOutput({tag, " WB"},         16'(wb_b),  16'(wb));
      checkOutput({tag, " M"},          16'(m_b),   16'(m));
      checkOutput({tag, " EX"},         16'(ex_b),  16'(ex));
    end
  endtask

  // Reset all instances, release, and step past the RUN_WAIT cycle.
  task automatic resetAll();
    applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    string tag;
    ctrl_wb = 2'b11;
    ctrl_m  = 2'b01;
    ctrl_ex = 4'b1010;
    applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;

    // Reset held: everything zero.
    repeat (2) @(negedge clk);
    #1;
    checkCtrl("in_reset", 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    checkOutput("in_reset stall_cnt", scnt_a, 16'd0);
    checkOutput("in_reset flush_cnt", fcnt_a, 16'd0);

    // Released: one settling bubble cycle, then pass-through.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCtrl("run_wait", 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    @(negedge clk);
    #1;
    checkCtrl("first_idle", 0, 1'b1, 1'b1, 1'b0, 2'b11, 2'b01, 4'b1010);

    // Directed table on instance A (LOAD_STALL=1); counts are pre-edge.
    //                  idexM  irt    rs     rt    ur    br    wb     m      ex       pc ifid fl pass stall  fcnt
    vecs[0]  = make_vec(2'b00, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0011, 1, 1, 0, 1, 16'd0, 16'd0);
    vecs[1]  = make_vec(2'b10, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0011, 0, 0, 0, 0, 16'd0, 16'd0);
    vecs[2]  = make_vec(2'b00, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 2'b01, 2'b10, 4'b1100, 1, 1, 0, 1, 16'd1, 16'd0);
    vecs[3]  = make_vec(2'b10, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 2'b11, 2'b11, 4'b1111, 1, 1, 0, 1, 16'd1, 16'd0);
    vecs[4]  = make_vec(2'b10, 5'd7,  5'd3,  5'd7, 1'b0, 1'b0, 2'b01, 2'b01, 4'b0101, 1, 1, 0, 1, 16'd1, 16'd0);
    vecs[5]  = make_vec(2'b10, 5'd7,  5'd3,  5'd7, 1'b1, 1'b0, 2'b01, 2'b01, 4'b0101, 0, 0, 0, 0, 16'd1, 16'd0);
    vecs[6]  = make_vec(2'b01, 5'd5,  5'd5,  5'd5, 1'b1, 1'b0, 2'b10, 2'b10, 4'b0110, 1, 1, 0, 1, 16'd2, 16'd0);
    vecs[7]  = make_vec(2'b00, 5'd5,  5'd5,  5'd0, 1'b0, 1'b1, 2'b11, 2'b00, 4'b1001, 1, 1, 1, 1, 16'd2, 16'd0);
    vecs[8]  = make_vec(2'b00, 5'd5,  5'd5,  5'd0, 1'b0, 1'b0, 2'b11, 2'b00, 4'b1001, 1, 1, 0, 1, 16'd2, 16'd1);
    vecs[9]  = make_vec(2'b10, 5'd9,  5'd9,  5'd0, 1'b0, 1'b1, 2'b11, 2'b11, 4'b0001, 0, 0, 0, 0, 16'd2, 16'd1);
    vecs[10] = make_vec(2'b00, 5'd9,  5'd9,  5'd0, 1'b0, 1'b1, 2'b10, 2'b11, 4'b0111, 1, 1, 1, 1, 16'd3, 16'd1);
    vecs[11] = make_vec(2'b00, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 2'b01, 2'b00, 4'b1000, 1, 1, 0, 1, 16'd3, 16'd2);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].idex_m, vecs[i].idex_rt, vecs[i].rs,
                    vecs[i].rt, vecs[i].use_rt, vecs[i].br);
      ctrl_wb = vecs[i].wb;
      ctrl_m  = vecs[i].m;
      ctrl_ex = vecs[i].ex;
      #1;
      tag = $sformatf("vec%0d", i);
      checkCtrl(tag, 0, vecs[i].exp_pc, vecs[i].exp_ifid, vecs[i].exp_flush,
                vecs[i].exp_pass ? vecs[i].wb : 2'b00,
                vecs[i].exp_pass ? vecs[i].m  : 2'b00,
                vecs[i].exp_pass ? vecs[i].ex : 4'b0000);
      checkOutput({tag, " stall_cnt"}, scnt_a, vecs[i].exp_stall);
      checkOutput({tag, " flush_cnt"}, fcnt_a, vecs[i].exp_fcnt);
    end

    // Instance B (LOAD_STALL=3): held hazard gives three bubbles.
    ctrl_wb = 2'b11; ctrl_m = 2'b01; ctrl_ex = 4'b1010;
    resetAll();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(2'b10, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
      #1;
      tag = $sformatf("ls3_bubble%0d", k);
      checkCtrl(tag, 1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
      checkOutput({tag, " stall_cnt"}, scnt_b, 16'(k));
    end
    @(negedge clk);
    applyStimulus(2'b00, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    #1;
    checkCtrl("ls3_resume", 1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b01, 4'b1010);
    checkOutput("ls3_resume stall_cnt", scnt_b, 16'd3);

    // Instance B: a branch during STALL is ignored.
    @(negedge clk);
    applyStimulus(2'b10, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    #1;
    checkCtrl("ls3_stall_branch", 1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    checkOutput("ls3_stall_branch flush_cnt", fcnt_b, 16'd0);

    // Instance B: asynchronous reset in the middle of a stall.
    resetAll();
    @(negedge clk);
    applyStimulus(2'b10, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("mid_stall stall_cnt_before", scnt_b, 16'd1);
    applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checkCtrl("mid_stall_reset", 1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    checkOutput("mid_stall_reset stall_cnt", scnt_b, 16'd0);
    checkOutput("mid_stall_reset flush_cnt", fcnt_b, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCtrl("mid_stall_run_wait", 1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000);
    @(negedge clk);
    #1;
    checkCtrl("mid_stall_no_residue", 1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b01, 4'b1010);
    checkOutput("mid_stall_no_residue stall_cnt", scnt_b, 16'd0);

    // Instance C (3-bit counters): ten hazards saturate at 3'h7.
    resetAll();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      applyStimulus(2'b10, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      if (k == 6) checkOutput("sat_reach stall_cnt", 16'(scnt_c), 16'd7);
    end
    checkOutput("sat_hold stall_cnt", 16'(scnt_c), 16'd7);
    checkOutput("sat_ref wide stall_cnt", scnt_a, 16'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/idex_hazard_ctrl.md
Name: idex_hazard_ctrl

Overview:
- Sits in the decode stage and drives the write side of the ID/EX pipeline register.
- Reads back the ID/EX register's latched M/rt fields to detect load-use hazards against the instruction held in IF/ID.
- Stalls PC and IF/ID and injects zeroed control bubbles into ID/EX.
- Flushes IF/ID on a taken branch and keeps hazard statistics counters.

Parameters:
LOAD_STALL, 1, number of bubble cycles inserted per load-use hazard (1..7)
CNT_W, 16, width of statistics counters

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous active-low reset
idex_M_i  input  2  M field latched in ID/EX; bit1 = MemRead, bit0 = MemWrite
idex_rt_i  input  5  rt latched in ID/EX (load destination)
ifid_rs_i  input  5  rs of instruction in IF/ID
ifid_rt_i  input  5  rt of instruction in IF/ID
ifid_use_rt_i  input  1  IF/ID instruction reads rt (R-type/store/beq)
branch_taken_i  input  1  branch in ID resolved taken this cycle
ctrl_WB_i  input  2  WB control from main control unit
ctrl_M_i  input  2  M control from main control unit
ctrl_EX_i  input  4  EX control from main control unit
WB_o  output  2  WB control to ID/EX (zero when bubbling)
M_o  output  2  M control to ID/EX (zero when bubbling)
EX_o  output  4  EX control to ID/EX (zero when bubbling)
pc_write_o  output  1  PC update enable
ifid_write_o  output  1  IF/ID load enable
ifid_flush_o  output  1  IF/ID clear to nop
stall_cnt_o  output  CNT_W  total bubble cycles inserted
flush_cnt_o  output  CNT_W  total taken-branch flushes

Behaviour:
- Reset (rst_i low, asynchronous): state=RUN_WAIT, stall counter=0, both statistics counters=0.
- While in reset and in RUN_WAIT, outputs are: pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, WB_o/M_o/EX_o=0.
- RUN_WAIT -> IDLE on the first rising edge after reset release. This gives exactly one bubble cycle of post-reset settling.
- Hazard condition: haz = idex_M_i[1] & (idex_rt_i != 0) & ((idex_rt_i == ifid_rs_i) | (ifid_use_rt_i & idex_rt_i == ifid_rt_i)).
- IDLE, haz=1:
  - pc_write_o=0, ifid_write_o=0, control outputs=0 (bubble), ifid_flush_o=0.
  - Next state STALL with rem=LOAD_STALL-1. If LOAD_STALL==1, next state stays IDLE; re-evaluation then sees the bubble in ID/EX, so haz=0.
  - stall_cnt_o increments.
- IDLE, haz=0, branch_taken_i=1:
  - pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, control outputs pass through.
  - flush_cnt_o increments.
- IDLE, no events: pass-through, pc_write_o=ifid_write_o=1, ifid_flush_o=0.
- STALL:
  - Bubble outputs as above; haz and branch_taken_i are ignored.
  - stall_cnt_o increments each cycle; rem decrements each cycle.
  - Exit to IDLE when rem==0 at the clock edge.
- Simultaneous haz and branch_taken_i: the stall wins. The branch is re-evaluated after the stall, because its operand is not yet valid.
- Outputs WB_o/M_o/EX_o/pc_write_o/ifid_write_o/ifid_flush_o are combinational from state and inputs; no added latency.
- Counters are registered and saturate at all-ones; no wrap.
- Asynchronous reset mid-STALL: returns immediately to RUN_WAIT and clears counters; no partial-stall residue.
- rt=0 never produces a hazard.

Decomposition:
- Shared package: state encoding (RUN_WAIT, IDLE, STALL); control field widths (WB 2, M 2, EX 4); M bit indices MEMREAD=1, MEMWRITE=0.
- Sub-module sat_counter (CNT_W, inc, asynchronous active-low reset), instantiated twice for the statistics counters.

Test Plan:
- Reset release with ctrl_EX_i=4'b1010 -> first cycle all controls 0 and pc_write_o=0; next cycle EX_o=4'b1010, pc_write_o=1.
- idex_M_i=2'b10, idex_rt_i=5, ifid_rs_i=5, LOAD_STALL=1 -> one cycle of pc_write_o=0, ifid_write_o=0, WB_o/M_o/EX_o=0; stall_cnt_o=1.
- Same hazard with LOAD_STALL=3 and hazard inputs held -> three bubble cycles, then IDLE; stall_cnt_o=3.
- idex_rt_i=0, MemRead=1, ifid_rs_i=0 -> no stall; ifid_use_rt_i=0 with only the rt match -> no stall.
- branch_taken_i=1 with no hazard -> ifid_flush_o=1 for one cycle; flush_cnt_o increments by 1.
- Hazard and branch in the same cycle -> stall only, ifid_flush_o=0.
- Saturation: force counter to 16'hFFFF -> stays 16'hFFFF.
- rst_i low during STALL -> outputs are immediately the reset values and counters read 0.
